// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between
// two masters, with a burst lock capped by a beat counter.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              DmemEn,
  output logic              DmemWrEn,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Data_Out,
  input  logic [DATA_W-1:0] Data_In
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic          prio;
  logic          owner_v;
  logic          owner;
  logic [BW-1:0] bcnt;
  logic          rv0;
  logic          rv1;

  logic [1:0] req;
  logic       at_cap;
  logic       gv;
  logic       w;
  logic       w_wr;
  logic       w_lock;

  assign req    = {req1, req0};
  assign at_cap = (bcnt == BW'(MAX_BURST));

  always_comb begin
    gv = 1'b0;
    w  = prio;
    if (Reset) begin
      gv = 1'b0;
    end else if (owner_v && req[owner] &&
                 (!at_cap || !req[~owner])) begin
      gv = 1'b1;
      w  = owner;
    end else if (owner_v && at_cap && req[~owner]) begin
      gv = 1'b1;
      w  = ~owner;
    end else if (req0 && req1) begin
      gv = 1'b1;
      w  = prio;
    end else if (req0 || req1) begin
      gv = 1'b1;
      w  = req1;
    end
  end

  assign w_wr   = w ? wr1 : wr0;
  assign w_lock = w ? lock1 : lock0;

  assign gnt0     = gv & ~w;
  assign gnt1     = gv & w;
  assign DmemEn   = gv;
  assign DmemWrEn = gv & w_wr;
  assign Mem_Addr = gv ? (w ? addr1 : addr0) : '0;
  assign Data_Out = gv ? (w ? wdata1 : wdata0) : '0;

  assign rvalid0 = rv0;
  assign rvalid1 = rv1;
  assign rdata0  = Data_In;
  assign rdata1  = Data_In;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prio    <= 1'b0;
      owner_v <= 1'b0;
      owner   <= 1'b0;
      bcnt    <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
    end else if (gv) begin
      prio <= ~w;
      if (w_lock) begin
        owner_v <= 1'b1;
        owner   <= w;
        if (owner_v && owner == w) begin
          if (!at_cap) bcnt <= bcnt + BW'(1);
        end else begin
          bcnt <= BW'(1);
        end
      end else begin
        owner_v <= 1'b0;
        bcnt    <= '0;
      end
      rv0 <= ~w & ~w_wr;
      rv1 <= w & ~w_wr;
    end else begin
      owner_v <= 1'b0;
      bcnt    <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a small
// behavioural data memory behind the dmem port.
module tb_dmem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req0, req1, lock0, lock1, wr0, wr1;
  logic [7:0]  addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1;
  logic        DmemEn, DmemWrEn;
  logic [7:0]  Mem_Addr;
  logic [63:0] Data_Out, Data_In;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  dmem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .req0(req0), .req1(req1),
    .lock0(lock0), .lock1(lock1),
    .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .DmemEn(DmemEn), .DmemWrEn(DmemWrEn),
    .Mem_Addr(Mem_Addr), .Data_Out(Data_Out),
    .Data_In(Data_In)
  );

  logic [63:0] mem [256];
  always @(posedge Clock) begin
    if (DmemEn && DmemWrEn) mem[Mem_Addr] <= Data_Out;
    Data_In <= mem[Mem_Addr];
  end

  typedef struct {
    logic       rst, r0, r1, l0, l1, w0, w1;
    logic [7:0] a0, a1;
    logic [63:0] d0;
    logic       g0, g1, we;
    logic [7:0] ma;
    logic       v0, v1, rdchk;
    logic [63:0] rd;
  } vec_t;

  localparam logic [63:0] WD = 64'hDEADBEEF00000001;

  function automatic vec_t mk(
    input logic [6:0]  in,
    input logic [7:0]  a0, a1,
    input logic [63:0] d0,
    input logic [2:0]  g,
    input logic [7:0]  ma,
    input logic [1:0]  rv,
    input logic        rdchk,
    input logic [63:0] rd);
    vec_t v;
    {v.rst, v.r0, v.r1, v.l0, v.l1, v.w0, v.w1} = in;
    v.a0 = a0;
    v.a1 = a1;
    v.d0 = d0;
    {v.g0, v.g1, v.we} = g;
    v.ma = ma;
    {v.v0, v.v1} = rv;
    v.rdchk = rdchk;
    v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tg);
    @(negedge Clock);
    Reset  = v.rst;
    req0   = v.r0;
    req1   = v.r1;
    lock0  = v.l0;
    lock1  = v.l1;
    wr0    = v.w0;
    wr1    = v.w1;
    addr0  = v.a0;
    addr1  = v.a1;
    wdata0 = v.d0;
    wdata1 = 64'h1111_2222_3333_4444;
    #1;
    chk({tg, " gnt0"}, 64'(gnt0), 64'(v.g0));
    chk({tg, " gnt1"}, 64'(gnt1), 64'(v.g1));
    chk({tg, " en"}, 64'(DmemEn), 64'(v.g0 | v.g1));
    chk({tg, " we"}, 64'(DmemWrEn), 64'(v.we));
    chk({tg, " addr"}, 64'(Mem_Addr), 64'(v.ma));
    chk({tg, " rv0"}, 64'(rvalid0), 64'(v.v0));
    chk({tg, " rv1"}, 64'(rvalid1), 64'(v.v1));
    if (v.we) chk({tg, " wdata"}, Data_Out, v.d0);
    if (v.rdchk) begin
      chk({tg, " rdata0"}, rdata0, v.rd);
      chk({tg, " rdata1"}, rdata1, v.rd);
    end
  endtask

  vec_t tbl [24];
  vec_t s;

  initial begin
    Reset = 1'b1;
    {req0, req1, lock0, lock1, wr0, wr1} = '0;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge Clock);

    // in = {rst,r0,r1,l0,l1,w0,w1}; g = {g0,g1,we}; rv = {v0,v1}
    tbl[0]  = mk(7'b1110000, 8'h10, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[1]  = mk(7'b0100010, 8'h05, 8'h20, WD, 3'b101, 8'h05, 2'b00, 0, 0);
    tbl[2]  = mk(7'b0100000, 8'h05, 8'h20, 0, 3'b100, 8'h05, 2'b00, 0, 0);
    tbl[3]  = mk(7'b0000000, 8'h05, 8'h20, 0, 3'b000, 8'h00, 2'b10, 1, WD);
    tbl[4]  = mk(7'b0000000, 8'h05, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[5]  = mk(7'b0000000, 8'h05, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[6]  = mk(7'b1000000, 8'h05, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[7]  = mk(7'b0110000, 8'h10, 8'h20, 0, 3'b100, 8'h10, 2'b00, 0, 0);
    tbl[8]  = mk(7'b0110000, 8'h10, 8'h20, 0, 3'b010, 8'h20, 2'b10, 0, 0);
    tbl[9]  = mk(7'b0110000, 8'h10, 8'h20, 0, 3'b100, 8'h10, 2'b01, 0, 0);
    tbl[10] = mk(7'b0110000, 8'h10, 8'h20, 0, 3'b010, 8'h20, 2'b10, 0, 0);
    tbl[11] = mk(7'b0000000, 8'h10, 8'h20, 0, 3'b000, 8'h00, 2'b01, 0, 0);
    tbl[12] = mk(7'b0000000, 8'h10, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[13] = mk(7'b0000000, 8'h10, 8'h20, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[14] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b100, 8'h30, 2'b00, 0, 0);
    tbl[15] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b100, 8'h30, 2'b10, 0, 0);
    tbl[16] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b100, 8'h30, 2'b10, 0, 0);
    tbl[17] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b100, 8'h30, 2'b10, 0, 0);
    tbl[18] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b010, 8'h40, 2'b10, 0, 0);
    tbl[19] = mk(7'b0111000, 8'h30, 8'h40, 0, 3'b100, 8'h30, 2'b01, 0, 0);
    tbl[20] = mk(7'b0000000, 8'h30, 8'h40, 0, 3'b000, 8'h00, 2'b10, 0, 0);
    tbl[21] = mk(7'b0000000, 8'h30, 8'h40, 0, 3'b000, 8'h00, 2'b00, 0, 0);
    tbl[22] = mk(7'b0110000, 8'h10, 8'h20, 0, 3'b010, 8'h20, 2'b00, 0, 0);
    tbl[23] = mk(7'b0000000, 8'h10, 8'h20, 0, 3'b000, 8'h00, 2'b01, 0, 0);

    for (int i = 0; i < 24; i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // uncontested lock: ten beats, counter must saturate not wrap
    for (int i = 0; i < 10; i++) begin
      s = mk(7'b0101000, 8'h50, 8'h60, 0, 3'b100, 8'h50,
             {i > 0, 1'b0}, 0, 0);
      apply(s, $sformatf("lock%0d", i));
    end
    s = mk(7'b0111000, 8'h50, 8'h60, 0, 3'b010, 8'h60, 2'b10, 0, 0);
    apply(s, "lock_sw");
    s = mk(7'b0000000, 8'h50, 8'h60, 0, 3'b000, 8'h00, 2'b01, 0, 0);
    apply(s, "lock_idle");

    // reset in the second beat of a requester-1 burst
    s = mk(7'b0010100, 8'h70, 8'h71, 0, 3'b010, 8'h71, 2'b00, 0, 0);
    apply(s, "rb_a");
    s = mk(7'b1110100, 8'h70, 8'h71, 0, 3'b000, 8'h00, 2'b01, 0, 0);
    apply(s, "rb_rst");
    s = mk(7'b0110100, 8'h70, 8'h71, 0, 3'b100, 8'h70, 2'b00, 0, 0);
    apply(s, "rb_rel");
    s = mk(7'b0000000, 8'h70, 8'h71, 0, 3'b000, 8'h00, 2'b10, 0, 0);
    apply(s, "rb_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-ported 256 x 64-bit data memory between the cardinal processor node (requester 0) and a second master such as a DMA/loader or network interface (requester 1). It sits between both masters and the dmem port, with grants decided in the same cycle as the request. Fairness is round-robin, with an optional lock for short bursts that is capped by a beat counter so neither master starves. Read data is returned the following cycle and tagged to the requester that issued it.

## Interface
- ADDR_W, 8, data-memory address width
- DATA_W, 64, data word width
- MAX_BURST, 4, max consecutive locked grants to one requester while the other is waiting (min 1)
- Clock  in  1  system clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- lock0 / lock1  in  1  with reqN: request to keep ownership for the next cycle
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  [0:ADDR_W-1]  word address
- wdata0 / wdata1  in  [0:DATA_W-1]  write data
- gnt0 / gnt1  out  1  combinational grant; the access is performed in this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid for requester N
- rdata0 / rdata1  out  [0:DATA_W-1]  both equal Data_In; qualified by rvalidN
- DmemEn  out  1  dmem enable
- DmemWrEn  out  1  dmem write enable
- Mem_Addr  out  [0:ADDR_W-1]  dmem address
- Data_Out  out  [0:DATA_W-1]  dmem write data
- Data_In  in  [0:DATA_W-1]  dmem read data, valid the cycle after a read

## Operation
- State:
  - prio: 1 bit; the requester favoured on a tie.
  - owner_v / owner: lock holder.
  - bcnt: consecutive grants to the owner, 0..MAX_BURST, saturating.
  - rv0 / rv1: the registered rvalid outputs.
- Winner selection is combinational and evaluated in this order:
  - Reset = 1: no grant.
  - owner_v, req[owner] = 1, and either bcnt < MAX_BURST or req[other] = 0: the owner wins.
  - owner_v, bcnt = MAX_BURST, and req[other] = 1: the other requester wins (forced switch).
  - Both requesting, no valid owner: requester prio wins.
  - Exactly one requesting: that requester wins.
  - Otherwise: no grant.
- Exactly one of gnt0/gnt1 is high when any grant is made.
- DmemEn = 1 on any grant. DmemWrEn, Mem_Addr and Data_Out are muxed from the winner's wr, addr and wdata.
- With no grant, DmemEn, DmemWrEn, Mem_Addr and Data_Out are all 0.
- Updates at posedge when a grant was made to winner W:
  - prio <= ~W.
  - If lockW = 1:
    - owner_v <= 1, owner <= W.
    - bcnt <= (owner_v && owner == W) ? min(bcnt + 1, MAX_BURST) : 1.
  - If lockW = 0: owner_v <= 0, bcnt <= 0.
  - rvW <= ~wrW, and the other requester's rv <= 0.
- Updates at posedge with no grant: owner_v <= 0, bcnt <= 0, rv0 <= 0, rv1 <= 0; prio is unchanged.
- If the owner drops req while owner_v = 1, ownership is released and normal round-robin applies in that cycle.

## Timing
- Reset values: prio = 0, owner_v = 0, bcnt = 0, rv0 = rv1 = 0.
- Outputs during Reset: gnt0 = gnt1 = 0 and DmemEn = DmemWrEn = 0, regardless of requests.
- Grant latency: 0 cycles. A request in cycle t is granted in cycle t if it wins.
- Write latency: the write commits at the posedge that ends the grant cycle.
- Read latency: rdataN is valid with rvalidN in cycle t+1, for exactly one cycle per granted read.
- Back-to-back reads by the same requester give continuous rvalid.
- Throughput: one access per cycle, with no idle cycle between different winners.
- Reset asserted mid-burst clears ownership at that edge. A read granted in the cycle before Reset still returns rvalid in the Reset cycle; the rv registers clear on the following edge.
- Requests are level-sensitive. A requester that loses holds req, addr, wr and wdata stable until granted.

## Test plan
- Single requester: req0 = 1, wr0 = 1, addr0 = 8'h05, wdata0 = 64'hDEADBEEF00000001 for 1 cycle, then a read of 8'h05.
  - Required: gnt0 in both cycles, DmemWrEn 1 then 0.
  - Required: rvalid0 = 1 one cycle after the read with rdata0 = 64'hDEADBEEF00000001; rvalid1 stays 0.
- Simultaneous reads, unlocked: req0 = req1 = 1 held for 4 cycles after reset.
  - Required: grants alternate 0, 1, 0, 1, and each rvalid follows its grant by one cycle.
- Burst cap: MAX_BURST = 4, req0 = lock0 = 1 continuously, req1 = 1 from cycle 0.
  - Required: gnt0 for 4 cycles, gnt1 in cycle 5, then gnt0 again.
- Lock uncontested: req0 = lock0 = 1 for 10 cycles, req1 = 0.
  - Required: gnt0 for all 10 cycles and bcnt saturates at 4.
  - Then req1 rises: gnt1 the next cycle.
- Reset mid-burst: Reset pulsed during cycle 2 of a locked burst by requester 1.
  - Required: no grants while Reset = 1.
  - After release with both requesting: gnt0 first (prio = 0).
- Idle: no requests for 3 cycles.
  - Required: DmemEn = DmemWrEn = 0, Mem_Addr = 0, rvalid0 = rvalid1 = 0, prio unchanged.
